// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory request/response bus between the fetch stage and the
//   instruction memory.
//
//   Signals
//     imem_req    master->slave  read request
//     imem_addr   master->slave  16-bit byte address of the request
//     imem_gnt    slave->master  request accepted when imem_req && imem_gnt
//     imem_rvalid slave->master  read data valid; responses return in order
//     imem_rdata  slave->master  16-bit instruction word
//
//   Modports
//     master : the fetch unit (issues requests, consumes responses)
//     slave  : the instruction memory (grants requests, returns data)
// ---------------------------------------------------------------------------
interface fetch_unit_if;

   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;

   // The fetch stage drives the request side and listens to grant/response.
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   // The memory grants requests and returns data in request order.
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage, directly upstream of decode_unit.
//   Holds the PC, issues 16-bit instruction reads to the instruction memory,
//   buffers returned instructions in a small in-order FIFO and presents the
//   FIFO head to decode. Honours decode's stall and the execute-stage branch
//   redirect.
//
//   Parameters
//     RESET_PC    PC value after reset (byte address)
//     FIFO_DEPTH  instruction buffer entries (power of 2, >= 2)
//     MAX_OUT     max outstanding memory requests (>= 1, <= FIFO_DEPTH)
//
//   Ports
//     clk              clock
//     reset            asynchronous, active-high reset
//     fetch_en         1 = fetching permitted
//     stall            decode stall; hold current output
//     is_branch_taken  one-cycle redirect strobe from execute
//     branch_target    absolute redirect byte address
//     imem             instruction memory bus (master side)
//     instr            instruction to decode, 16'h0000 (NOP) when not valid
//     instr_pc         PC of instr, 0 when not valid
//     instr_valid      instr holds a real instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          MAX_OUT    = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_en,
   input  logic               stall,
   input  logic               is_branch_taken,
   input  logic [15:0]        branch_target,
   fetch_unit_if.master       imem,
   output logic [15:0]        instr,
   output logic [15:0]        instr_pc,
   output logic               instr_valid
);

   // Pointer/count widths. The request-address queue is sized to MAX_OUT,
   // which need not be a power of two, so its pointers wrap explicitly.
   localparam int FPW = $clog2(FIFO_DEPTH);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);
   localparam int OCW = $clog2(MAX_OUT + 1);
   localparam int QPW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int SW  = FCW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [15:0]       pc;
   logic [OCW-1:0]    outstanding;
   logic [OCW-1:0]    discard;

   // Instruction buffer: data word plus the PC it was fetched from.
   logic [15:0]       fifo_data [FIFO_DEPTH];
   logic [15:0]       fifo_pc   [FIFO_DEPTH];
   logic [FPW-1:0]    rd_ptr;
   logic [FPW-1:0]    wr_ptr;
   logic [FCW-1:0]    fifo_count;

   // Addresses of requests that have been accepted but not yet answered.
   logic [15:0]       req_pc_q [MAX_OUT];
   logic [QPW-1:0]    req_rd;
   logic [QPW-1:0]    req_wr;

   logic              redirect;
   logic              resp;
   logic              accept;
   logic              can_issue;
   logic              push;
   logic              pop;
   logic [SW-1:0]     credit_used;
   logic [OCW-1:0]    resp_remaining;
   logic [15:0]       resp_pc;

   // Wrap a request-queue pointer at MAX_OUT entries.
   function automatic logic [QPW-1:0] q_next(input logic [QPW-1:0] p);
      if (p == QPW'(MAX_OUT - 1)) begin
         return '0;
      end
      return p + QPW'(1);
   endfunction

   // Handshake decode. A redirect is only honoured once fetching has started
   // (IDLE ignores it). A response is only meaningful while something is in
   // flight, which also keeps the counters from underflowing on a stray
   // rvalid. The issue decision uses registered counts only, so a pop in the
   // same cycle does not free a credit until the next cycle.
   assign redirect       = is_branch_taken && (state != IDLE);
   assign resp           = imem.imem_rvalid && (outstanding != '0);
   assign credit_used    = SW'(fifo_count) + SW'(outstanding);
   assign can_issue      = (state != IDLE) && fetch_en && !is_branch_taken
                           && (outstanding < OCW'(MAX_OUT))
                           && (credit_used < SW'(FIFO_DEPTH));
   assign accept         = can_issue && imem.imem_gnt;
   assign resp_remaining = outstanding - OCW'(resp);
   assign resp_pc        = req_pc_q[req_rd];

   // A response is kept only when nothing is waiting to be discarded and no
   // redirect arrives in the same cycle (that response is stale too).
   assign push = resp && !redirect && (discard == '0);
   assign pop  = instr_valid && !stall && !is_branch_taken;

   // Memory request side is purely combinational from the PC and credits.
   assign imem.imem_req  = can_issue;
   assign imem.imem_addr = pc;

   // Show-ahead output: the FIFO head goes straight to decode, and a NOP
   // with PC 0 is presented whenever the buffer is empty.
   assign instr_valid = (fifo_count != '0);
   assign instr       = instr_valid ? fifo_data[rd_ptr] : 16'h0000;
   assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : 16'h0000;

   // State register for the fetch FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A redirect goes to FLUSH only if stale requests will
   // still be in flight after this cycle; otherwise the new path can start
   // straight away in FETCH. FLUSH returns to FETCH on the response that
   // retires the last stale request. FETCH drops back to IDLE only once
   // fetching is disabled and the memory has nothing left to return.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (fetch_en) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            if (redirect) begin
               state_next = (resp_remaining != '0) ? FLUSH : FETCH;
            end else if (!fetch_en && (outstanding == '0)) begin
               state_next = IDLE;
            end
         end
         FLUSH: begin
            if (redirect) begin
               state_next = (resp_remaining != '0) ? FLUSH : FETCH;
            end else if (resp && (discard == OCW'(1))) begin
               state_next = FETCH;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Program counter. A redirect wins over everything; otherwise the PC
   // advances by one halfword per accepted request and wraps at 16 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= branch_target;
      end else if (accept) begin
         pc <= pc + 16'd2;
      end
   end

   // Outstanding request count. Accept and response in the same cycle
   // cancel out. Requests are never accepted in a redirect cycle, so the
   // count stays exact across redirects.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
      end else begin
         outstanding <= outstanding + OCW'(accept) - OCW'(resp);
      end
   end

   // Discard counter: number of stale responses still to be dropped. A
   // redirect reloads it with everything still in flight after this cycle,
   // which also handles a second redirect arriving while already flushing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         discard <= '0;
      end else if (redirect) begin
         discard <= resp_remaining;
      end else if (resp && (discard != '0)) begin
         discard <= discard - OCW'(1);
      end
   end

   // Request-address queue pointers. Every response retires the oldest
   // entry, whether its data is kept or dropped, so the queue always lines
   // up with the in-order responses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_rd <= '0;
         req_wr <= '0;
      end else begin
         if (accept) begin
            req_wr <= q_next(req_wr);
         end
         if (resp) begin
            req_rd <= q_next(req_rd);
         end
      end
   end

   // Request-address storage; the entry is only read once its pointer has
   // been written, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_pc_q[req_wr] <= pc;
      end
   end

   // Instruction buffer control. A redirect empties the buffer so decode
   // sees no valid instruction in the following cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else if (redirect) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + FPW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + FPW'(1);
         end
         fifo_count <= fifo_count + FCW'(push) - FCW'(pop);
      end
   end

   // Instruction buffer storage, written with the returned word and the PC
   // of the request it answers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= imem.imem_rdata;
         fifo_pc[wr_ptr]   <= resp_pc;
      end
   end

   // The credit rule reserves a buffer slot for every request in flight, so
   // a push into a full buffer without a pop can only mean a broken design.
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && (fifo_count == FCW'(FIFO_DEPTH))));

   // Every response must be answering a request.
   a_resp_has_req: assert property (@(posedge clk) disable iff (reset)
      !(imem.imem_rvalid && (outstanding == '0)));

endmodule
